// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Hazard and forwarding controller for a 5-stage pipe (IF ID EX MEM WB).
//   It resolves load-use hazards with a one-cycle stall and one bubble, and
//   taken branches/jumps with a two-instruction flush. It drains the pipe for
//   DRAIN_CYCLES after a CSR write or mret leaves EX. It also picks the EX
//   operand forwarding sources and counts the cycles in which the PC is held.
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   rs1_id, rs2_id              source registers of the instruction in ID
//   use_rs1_id, use_rs2_id      ID instruction actually reads rs1 / rs2
//   rs1_ex, rs2_ex, rd_ex       register fields of the instruction in EX
//   rf_en_ex, is_load_ex        EX writes RF / EX is a load
//   br_taken_ex                 taken branch or jump resolved in EX
//   csr_wr_ex, is_mret_ex       EX writes a CSR / EX is mret
//   rd_mem, rf_en_mem,          destination info of MEM
//   is_load_mem
//   rd_wb, rf_en_wb             destination info of WB
//   stall_if, stall_id          hold PC / hold IF-ID (always equal)
//   flush_id                    clear IF-ID to NOP
//   flush_ex                    load a bubble into ID-EX
//   fwd_a, fwd_b                00 RF, 01 MEM result, 10 WB result
//   busy                        FSM is in DRAIN (mirrors the state register)
//   stall_cnt                   cycles with stall_if=1, wraps

module hazard_ctrl_unit #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic             rf_en_ex,
    input  logic             is_load_ex,
    input  logic             br_taken_ex,
    input  logic             csr_wr_ex,
    input  logic             is_mret_ex,
    input  logic [4:0]       rd_mem,
    input  logic             rf_en_mem,
    input  logic             is_load_mem,
    input  logic [4:0]       rd_wb,
    input  logic             rf_en_wb,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            load_use;
    logic            stall_raw, flush_id_raw, flush_ex_raw, busy_raw;
    logic [1:0]      fwd_a_raw, fwd_b_raw;

    // A load in MEM has no result yet, so it can never be a forward source;
    // that case is covered by the load-use stall one cycle earlier.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (rf_en_mem && !is_load_mem && (rd_mem == rs)) sel = 2'b01;
            else if (rf_en_wb && (rd_wb == rs))              sel = 2'b10;
        end
        return sel;
    endfunction

    assign fwd_a_raw = fwd_sel(rs1_ex);
    assign fwd_b_raw = fwd_sel(rs2_ex);

    assign load_use = is_load_ex && rf_en_ex && (rd_ex != 5'd0) &&
                      ((use_rs1_id && (rs1_id == rd_ex)) ||
                       (use_rs2_id && (rs2_id == rd_ex)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_raw    = 1'b0;
        flush_id_raw = 1'b0;
        flush_ex_raw = 1'b0;
        busy_raw     = 1'b0;
        case (state_q)
            RUN: begin
                if (csr_wr_ex || is_mret_ex) begin
                    stall_raw    = 1'b1;
                    flush_id_raw = 1'b1;
                    state_d      = DRAIN;
                    cnt_d        = DW'(DRAIN_CYCLES - 1);
                end else if (br_taken_ex) begin
                    // The branch wins over a load-use: the stalled ID
                    // instruction is on the wrong path anyway.
                    flush_id_raw = 1'b1;
                    flush_ex_raw = 1'b1;
                end else if (load_use) begin
                    stall_raw    = 1'b1;
                    flush_ex_raw = 1'b1;
                end
            end
            DRAIN: begin
                // EX only holds bubbles here, so branch/load-use are ignored.
                stall_raw    = 1'b1;
                flush_id_raw = 1'b1;
                busy_raw     = 1'b1;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // While reset is held every output is forced to its idle value,
    // independent of the inputs.
    assign stall_if = rst & stall_raw;
    assign stall_id = rst & stall_raw;
    assign flush_id = rst & flush_id_raw;
    assign flush_ex = rst & flush_ex_raw;
    assign busy     = rst & busy_raw;
    assign fwd_a    = rst ? fwd_a_raw : 2'b00;
    assign fwd_b    = rst ? fwd_b_raw : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          stall_cnt <= '0;
        else if (stall_if) stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic        use_rs1_id, use_rs2_id, rf_en_ex, is_load_ex, br_taken_ex;
    logic        csr_wr_ex, is_mret_ex, rf_en_mem, is_load_mem, rf_en_wb;
    logic        stall_if, stall_id, flush_id, flush_ex, busy;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt;

    logic        s_stall_if, s_stall_id, s_flush_id, s_flush_ex, s_busy;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rf_en_ex(rf_en_ex),
        .is_load_ex(is_load_ex), .br_taken_ex(br_taken_ex), .csr_wr_ex(csr_wr_ex),
        .is_mret_ex(is_mret_ex), .rd_mem(rd_mem), .rf_en_mem(rf_en_mem),
        .is_load_mem(is_load_mem), .rd_wb(rd_wb), .rf_en_wb(rf_en_wb),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy), .stall_cnt(stall_cnt)
    );

    hazard_ctrl_unit #(.DRAIN_CYCLES(2), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rf_en_ex(rf_en_ex),
        .is_load_ex(is_load_ex), .br_taken_ex(br_taken_ex), .csr_wr_ex(csr_wr_ex),
        .is_mret_ex(is_mret_ex), .rd_mem(rd_mem), .rf_en_mem(rf_en_mem),
        .is_load_mem(is_load_mem), .rd_wb(rd_wb), .rf_en_wb(rf_en_wb),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .flush_id(s_flush_id),
        .flush_ex(s_flush_ex), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .busy(s_busy),
        .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] rs1_id, rs2_id;
        logic       use1, use2;
        logic [4:0] rs1_ex, rs2_ex, rd_ex;
        logic       rf_en_ex, is_load_ex, br;
        logic [4:0] rd_mem;
        logic       rf_en_mem, is_load_mem;
        logic [4:0] rd_wb;
        logic       rf_en_wb;
        logic       e_stall, e_flush_id, e_flush_ex;
        logic [1:0] e_fwd_a, e_fwd_b;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_id = 0; rs2_id = 0; use_rs1_id = 0; use_rs2_id = 0;
        rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rf_en_ex = 0; is_load_ex = 0;
        br_taken_ex = 0; csr_wr_ex = 0; is_mret_ex = 0;
        rd_mem = 0; rf_en_mem = 0; is_load_mem = 0; rd_wb = 0; rf_en_wb = 0;
    endtask

    task automatic check_outs(input string name, input logic e_stall, input logic e_fid,
                              input logic e_fex, input logic e_busy,
                              input logic [1:0] e_fa, input logic [1:0] e_fb);
        check({name, ".stall_if"}, 32'(stall_if), 32'(e_stall));
        check({name, ".stall_id"}, 32'(stall_id), 32'(e_stall));
        check({name, ".flush_id"}, 32'(flush_id), 32'(e_fid));
        check({name, ".flush_ex"}, 32'(flush_ex), 32'(e_fex));
        check({name, ".busy"},     32'(busy),     32'(e_busy));
        check({name, ".fwd_a"},    32'(fwd_a),    32'(e_fa));
        check({name, ".fwd_b"},    32'(fwd_b),    32'(e_fb));
    endtask

    // Advance to the next drive point (negedge); count the stall seen at the posedge.
    task automatic step(input logic exp_stall);
        @(posedge clk);
        if (exp_stall) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic add_vec(input string n,
                           input logic [4:0] r1i, input logic [4:0] r2i, input logic u1, input logic u2,
                           input logic [4:0] r1e, input logic [4:0] r2e, input logic [4:0] rde,
                           input logic rfe, input logic lde, input logic br,
                           input logic [4:0] rdm, input logic rfm, input logic ldm,
                           input logic [4:0] rdw, input logic rfw,
                           input logic es, input logic efi, input logic efe,
                           input logic [1:0] efa, input logic [1:0] efb);
        vec_t v;
        v.name = n; v.rs1_id = r1i; v.rs2_id = r2i; v.use1 = u1; v.use2 = u2;
        v.rs1_ex = r1e; v.rs2_ex = r2e; v.rd_ex = rde; v.rf_en_ex = rfe; v.is_load_ex = lde;
        v.br = br; v.rd_mem = rdm; v.rf_en_mem = rfm; v.is_load_mem = ldm;
        v.rd_wb = rdw; v.rf_en_wb = rfw;
        v.e_stall = es; v.e_flush_id = efi; v.e_flush_ex = efe; v.e_fwd_a = efa; v.e_fwd_b = efb;
        vecs.push_back(v);
    endtask

    initial begin
        //        name          r1i r2i u1 u2 r1e r2e rde rfe lde br rdm rfm ldm rdw rfw  st fi fe fa     fb
        add_vec("idle",          0,  0, 0, 0,  0,  0,  0, 0,  0, 0,  0, 0,  0,  0, 0,  0, 0, 0, 2'b00, 2'b00);
        add_vec("lu_rs1",        5,  1, 1, 1,  0,  0,  5, 1,  1, 0,  0, 0,  0,  0, 0,  1, 0, 1, 2'b00, 2'b00);
        add_vec("lu_rs1_unused", 5,  1, 0, 1,  0,  0,  5, 1,  1, 0,  0, 0,  0,  0, 0,  0, 0, 0, 2'b00, 2'b00);
        add_vec("lu_rd0",        0,  0, 1, 1,  0,  0,  0, 1,  1, 0,  0, 0,  0,  0, 0,  0, 0, 0, 2'b00, 2'b00);
        add_vec("lu_rs2",        3,  9, 1, 1,  0,  0,  9, 1,  1, 0,  0, 0,  0,  0, 0,  1, 0, 1, 2'b00, 2'b00);
        add_vec("lu_no_rfen",    9,  0, 1, 0,  0,  0,  9, 0,  1, 0,  0, 0,  0,  0, 0,  0, 0, 0, 2'b00, 2'b00);
        add_vec("alu_no_lu",     9,  0, 1, 0,  0,  0,  9, 1,  0, 0,  0, 0,  0,  0, 0,  0, 0, 0, 2'b00, 2'b00);
        add_vec("fwd_mem_wins",  0,  0, 0, 0,  7,  7,  0, 0,  0, 0,  7, 1,  0,  7, 1,  0, 0, 0, 2'b01, 2'b01);
        add_vec("fwd_x0",        0,  0, 0, 0,  3,  0,  0, 0,  0, 0,  3, 1,  0,  0, 1,  0, 0, 0, 2'b01, 2'b00);
        add_vec("fwd_mem_load",  0,  0, 0, 0,  4,  9,  0, 0,  0, 0,  4, 1,  1,  4, 1,  0, 0, 0, 2'b10, 2'b00);
        add_vec("fwd_no_en",     0,  0, 0, 0,  8,  8,  0, 0,  0, 0,  8, 0,  0,  8, 0,  0, 0, 0, 2'b00, 2'b00);
        add_vec("fwd_wb_only",   0,  0, 0, 0, 13, 12,  0, 0,  0, 0,  0, 0,  0, 12, 1,  0, 0, 0, 2'b00, 2'b10);
        add_vec("br_and_lu",     5,  0, 1, 0,  0,  0,  5, 1,  1, 1,  0, 0,  0,  0, 0,  0, 1, 1, 2'b00, 2'b00);
        add_vec("br_only",       0,  0, 0, 0,  0,  0,  0, 0,  0, 1,  0, 0,  0,  0, 0,  0, 1, 1, 2'b00, 2'b00);

        // Reset: outputs idle even with inputs that would otherwise drive them.
        clear_inputs();
        csr_wr_ex = 1; rs1_ex = 7; rd_mem = 7; rf_en_mem = 1; rs2_ex = 6; rd_wb = 6; rf_en_wb = 1;
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0, 2'b00, 2'b00);
        check("reset.stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);

        // Combinational table; state stays RUN throughout.
        foreach (vecs[i]) begin
            rs1_id = vecs[i].rs1_id; rs2_id = vecs[i].rs2_id;
            use_rs1_id = vecs[i].use1; use_rs2_id = vecs[i].use2;
            rs1_ex = vecs[i].rs1_ex; rs2_ex = vecs[i].rs2_ex; rd_ex = vecs[i].rd_ex;
            rf_en_ex = vecs[i].rf_en_ex; is_load_ex = vecs[i].is_load_ex;
            br_taken_ex = vecs[i].br; rd_mem = vecs[i].rd_mem; rf_en_mem = vecs[i].rf_en_mem;
            is_load_mem = vecs[i].is_load_mem; rd_wb = vecs[i].rd_wb; rf_en_wb = vecs[i].rf_en_wb;
            #1;
            check_outs(vecs[i].name, vecs[i].e_stall, vecs[i].e_flush_id, vecs[i].e_flush_ex,
                       1'b0, vecs[i].e_fwd_a, vecs[i].e_fwd_b);
            step(vecs[i].e_stall);
        end
        clear_inputs();
        #1;
        check("table.stall_cnt", stall_cnt, 32'(exp_cnt));
        check("table.busy_after", 32'(busy), 32'd0);

        // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then WB forward.
        clear_inputs();
        rd_ex = 5; rf_en_ex = 1; is_load_ex = 1; rs1_id = 5; rs2_id = 1; use_rs1_id = 1; use_rs2_id = 1;
        #1; check_outs("lu_seq.c1", 1, 0, 1, 0, 2'b00, 2'b00);
        step(1);
        clear_inputs();
        rs1_id = 5; rs2_id = 1; use_rs1_id = 1; use_rs2_id = 1;
        rd_mem = 5; rf_en_mem = 1; is_load_mem = 1;
        #1; check_outs("lu_seq.c2", 0, 0, 0, 0, 2'b00, 2'b00);
        step(0);
        clear_inputs();
        rs1_ex = 5; rs2_ex = 1; rd_ex = 6; rf_en_ex = 1; rd_wb = 5; rf_en_wb = 1;
        #1; check_outs("lu_seq.c3", 0, 0, 0, 0, 2'b10, 2'b00);
        step(0);

        // CSR write: 3 stall cycles, 2 busy cycles; DRAIN ignores branch/load-use.
        clear_inputs();
        csr_wr_ex = 1;
        #1; check_outs("csr.c1", 1, 1, 0, 0, 2'b00, 2'b00);
        step(1);
        clear_inputs();
        br_taken_ex = 1;
        #1; check_outs("csr.d1", 1, 1, 0, 1, 2'b00, 2'b00);
        step(1);
        clear_inputs();
        rd_ex = 5; rf_en_ex = 1; is_load_ex = 1; rs1_id = 5; use_rs1_id = 1;
        #1; check_outs("csr.d2", 1, 1, 0, 1, 2'b00, 2'b00);
        step(1);
        clear_inputs();
        #1; check_outs("csr.run", 0, 0, 0, 0, 2'b00, 2'b00);
        check("csr.stall_cnt", stall_cnt, 32'(exp_cnt));
        step(0);

        // mret, then async reset in the 2nd DRAIN cycle.
        is_mret_ex = 1;
        #1; check_outs("mret.c1", 1, 1, 0, 0, 2'b00, 2'b00);
        step(1);
        clear_inputs();
        #1; check_outs("mret.d1", 1, 1, 0, 1, 2'b00, 2'b00);
        step(1);
        rs1_ex = 7; rd_mem = 7; rf_en_mem = 1;
        #1; check("mret.d2.busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_outs("mret.rst", 0, 0, 0, 0, 2'b00, 2'b00);
        check("mret.rst.stall_cnt", stall_cnt, 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1; check_outs("mret.after_rst", 0, 0, 0, 0, 2'b00, 2'b00);
        step(0);

        // 17 stall cycles from reset: 4-bit counter wraps to 1.
        rd_ex = 5; rf_en_ex = 1; is_load_ex = 1; rs2_id = 5; use_rs2_id = 1;
        for (int i = 0; i < 17; i++) step(1);
        clear_inputs();
        #1;
        check("wrap.small_cnt", 32'(s_stall_cnt), 32'd1);
        check("wrap.main_cnt", stall_cnt, 32'(exp_cnt));
        check("wrap.main_cnt17", stall_cnt, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
